reg_bank_ctrl: RTL and testbench
================================

Name: reg_bank_ctrl

Overview:
- Parametrised bank of DEPTH general-purpose registers, each WIDTH bits.
- Clocked successor to the single-register and instruction-register blocks.
- Each register supports clear, full load, lane (partial) load, increment and decrement under per-register enable.
- Two independent combinational read ports feed the ALU and address muxes.
- A per-register wrap pulse flags counter overflow and underflow.

Parameters:
- WIDTH, 16, register width in bits; must be a multiple of LANE.
- DEPTH, 4, number of registers; must be at least 2.
- LANE, 8, width of the lane loaded by partial-load operations.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- enable  in  DEPTH  per-register write enable mask; any number of bits may be set.
- funsel  in  3  operation select, applied to every enabled register.
- load  in  WIDTH  load data.
- lane_sel  in  max(1,$clog2(WIDTH/LANE))  lane index for lane load.
- sel_a  in  $clog2(DEPTH)  read port A register index.
- sel_b  in  $clog2(DEPTH)  read port B register index.
- out_a  out  WIDTH  contents of register sel_a.
- out_b  out  WIDTH  contents of register sel_b.
- wrap  out  DEPTH  one-cycle pulse per register on increment/decrement wrap.

Behaviour:
- All state updates on posedge clk.
- rst has priority over every other input.
  - Reset: all registers = 0, wrap = 0.
  - out_a and out_b therefore read 0 in the cycle after reset.
- funsel encoding, applied to register i when enable[i]=1:
  - 000: clear to 0.
  - 001: full load, reg = load.
  - 010: decrement by 1, modulo 2^WIDTH.
  - 011: increment by 1, modulo 2^WIDTH.
  - 100: lane load, reg[lane_sel*LANE +: LANE] = load[LANE-1:0]; other bits hold.
  - 101: lane clear, reg[lane_sel*LANE +: LANE] = 0; other bits hold.
  - 110, 111: reserved; register holds, no wrap.
- enable[i]=0: register i holds regardless of funsel.
- lane_sel ≥ WIDTH/LANE on op 100/101: register holds; no partial write.
- Multiple enable bits set: all selected registers perform the same op in the same cycle.
  - Each register uses its own current value for increment/decrement.
- Read ports are purely combinational from register state.
  - A write is visible on out_a/out_b starting the cycle after the clock edge (no bypass).
- sel_a may equal sel_b; both ports return the same value.
- wrap[i]:
  - Registered; asserted for exactly the cycle following an edge where register i incremented from all-ones or decremented from zero.
  - Otherwise 0.
- Consecutive wrapping operations keep wrap[i] high on each such cycle.
- rst asserted mid-sequence: next cycle shows all-zero registers and wrap=0; the pending op is discarded.

Optional Feature:
- Macro: REG_BANK_SATURATE_EN.
- Defined:
  - Increment of all-ones holds all-ones.
  - Decrement of zero holds zero.
  - wrap[i] pulses on that saturating attempt and now means "saturation hit".
- Undefined: modulo wrap as above, and wrap[i] pulses on the wrap.
- All other ops are identical in both builds.

Decomposition:
- Shared package reg_bank_pkg holds:
  - funsel op constants: OP_CLR, OP_LOAD, OP_DEC, OP_INC, OP_LANE_LD, OP_LANE_CLR.
  - a function computing the lane count (WIDTH/LANE).
- One natural sub-module: reg_bank_cell.
  - A single WIDTH register implementing all ops and its own wrap flag.
  - Instantiated DEPTH times by generate.
- The top level holds only the two read muxes and parameter checks.

Test Plan (WIDTH=16, DEPTH=4, LANE=8):
- Reset:
  - Stimulus: rst=1 for one cycle after loading reg2=0xBEEF.
  - Required: sel_a=2 gives out_a=0x0000, wrap=4'b0000.
- Full and lane load:
  - Stimulus: enable=4'b0001, funsel=001, load=0x1234; then funsel=100, lane_sel=1, load=0x00AB.
  - Required: out_a(sel 0)=0x1234, then 0xAB34.
- Increment wrap:
  - Stimulus: reg1=0xFFFF, enable=4'b0010, funsel=011.
  - Required: next cycle reg1=0x0000, wrap=4'b0010.
  - Required: one cycle later, with no op, wrap=4'b0000.
  - With REG_BANK_SATURATE_EN, the same stimulus gives reg1=0xFFFF and wrap=4'b0010.
- Multi-enable decrement:
  - Stimulus: reg0=0x0005, reg3=0x0000; enable=4'b1001, funsel=010.
  - Required: reg0=0x0004, reg3=0xFFFF, wrap=4'b1000.
- Reserved op, out-of-range lane, and reset priority:
  - Stimulus: funsel=110 on all registers.
  - Required: registers unchanged.
  - Stimulus: funsel=100, lane_sel=2 (out of range for 2 lanes).
  - Required: no change.
  - Stimulus: rst=1 together with enable=4'b1111, funsel=011.
  - Required: all registers = 0.
- Dual read:
  - Stimulus: sel_a=sel_b=3 with reg3=0x5A5A.
  - Required: out_a=out_b=0x5A5A.
  - Stimulus: write reg3=0x0001 on edge N.
  - Required: both ports read 0x5A5A before edge N and 0x0001 from cycle N+1.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared operation codes and lane helpers for the register bank.
// The REG_BANK_SATURATE_EN build option is handled in reg_bank_cell.
package reg_bank_pkg;

  localparam logic [2:0] OP_CLR      = 3'b000;
  localparam logic [2:0] OP_LOAD     = 3'b001;
  localparam logic [2:0] OP_DEC      = 3'b010;
  localparam logic [2:0] OP_INC      = 3'b011;
  localparam logic [2:0] OP_LANE_LD  = 3'b100;
  localparam logic [2:0] OP_LANE_CLR = 3'b101;

  function automatic int laneCount(input int width, input int lane);
    return width / lane;
  endfunction

  // A single-lane register still gets a 1-bit lane select so the port never collapses to zero width.
  function automatic int laneSelWidth(input int width, input int lane);
    int n;
    n = laneCount(width, lane);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_ctrl_if.sv
// Command and read-back bundle shared by the register bank and whoever drives it.
interface reg_bank_ctrl_if
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LANE  = 8
);

  localparam int LSW = laneSelWidth(WIDTH, LANE);
  localparam int SW  = $clog2(DEPTH);

  logic [DEPTH-1:0] enable;
  logic [2:0]       funsel;
  logic [WIDTH-1:0] load;
  logic [LSW-1:0]   lane_sel;
  logic [SW-1:0]    sel_a;
  logic [SW-1:0]    sel_b;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [DEPTH-1:0] wrap;

  modport master (
    output enable, funsel, load, lane_sel, sel_a, sel_b,
    input  out_a, out_b, wrap
  );

  modport slave (
    input  enable, funsel, load, lane_sel, sel_a, sel_b,
    output out_a, out_b, wrap
  );

endinterface

// File: rtl/reg_bank_cell.sv
// One bank register with clear/load/lane/inc/dec ops and a registered wrap flag.
// Define REG_BANK_SATURATE_EN to make inc/dec saturate instead of wrapping.
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 8,
  localparam int LSW  = laneSelWidth(WIDTH, LANE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [2:0]       funsel_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic [LSW-1:0]   lane_sel_i,
  output logic [WIDTH-1:0] value_o,
  output logic             wrap_o
);

  localparam int unsigned NLANES = laneCount(WIDTH, LANE);

  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  int unsigned      laneIdx;

  // wrap_d marks the boundary attempt; whether the value rolls over or sticks depends on the build.
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    laneIdx = 32'(lane_sel_i);
    if (en_i) begin
      case (funsel_i)
        OP_CLR:  value_d = '0;
        OP_LOAD: value_d = load_i;
        OP_DEC: begin
          if (value_q == '0) begin
            wrap_d = 1'b1;
`ifdef REG_BANK_SATURATE_EN
            value_d = value_q;
`else
            value_d = '1;
`endif
          end else begin
            value_d = value_q - WIDTH'(1);
          end
        end
        OP_INC: begin
          if (value_q == '1) begin
            wrap_d = 1'b1;
`ifdef REG_BANK_SATURATE_EN
            value_d = value_q;
`else
            value_d = '0;
`endif
          end else begin
            value_d = value_q + WIDTH'(1);
          end
        end
        OP_LANE_LD: begin
          if (laneIdx < NLANES) value_d[laneIdx*LANE +: LANE] = load_i[LANE-1:0];
        end
        OP_LANE_CLR: begin
          if (laneIdx < NLANES) value_d[laneIdx*LANE +: LANE] = '0;
        end
        default: value_d = value_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign value_o = value_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/reg_bank_ctrl.sv
// DEPTH-entry register bank: generated cells plus two combinational read ports.
// Build option REG_BANK_SATURATE_EN switches every cell to saturating inc/dec.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LANE  = 8
) (
  input  logic           clk,
  input  logic           rst,
  reg_bank_ctrl_if.slave bus
);

  logic [WIDTH-1:0] cellVal [DEPTH];
  logic [DEPTH-1:0] wrapVec;

  if (DEPTH < 2) begin : g_bad_depth
    $error("reg_bank_ctrl: DEPTH must be at least 2");
  end
  if (LANE < 1 || (WIDTH % LANE) != 0) begin : g_bad_lane
    $error("reg_bank_ctrl: WIDTH must be a positive multiple of LANE");
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    reg_bank_cell #(
      .WIDTH(WIDTH),
      .LANE (LANE)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .en_i      (bus.enable[i]),
      .funsel_i  (bus.funsel),
      .load_i    (bus.load),
      .lane_sel_i(bus.lane_sel),
      .value_o   (cellVal[i]),
      .wrap_o    (wrapVec[i])
    );
  end

  // No write bypass: reads reflect state committed at the previous edge.
  assign bus.out_a = cellVal[bus.sel_a];
  assign bus.out_b = cellVal[bus.sel_b];
  assign bus.wrap  = wrapVec;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed table-driven bench for reg_bank_ctrl (16x4, 8-bit lanes) plus a 24-bit,
// 3-lane instance for the out-of-range lane select case. Honours REG_BANK_SATURATE_EN.
module tb_reg_bank_ctrl;

  logic clk;
  logic rst;

  reg_bank_ctrl_if #(.WIDTH(16), .DEPTH(4), .LANE(8)) bus ();
  reg_bank_ctrl_if #(.WIDTH(24), .DEPTH(2), .LANE(8)) bus2 ();

  reg_bank_ctrl #(.WIDTH(16), .DEPTH(4), .LANE(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  reg_bank_ctrl #(.WIDTH(24), .DEPTH(2), .LANE(8)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REG_BANK_SATURATE_EN
  localparam logic [15:0] INC_TOP  = 16'hFFFF;
  localparam logic [15:0] DEC_ZERO = 16'h0000;
  localparam logic [15:0] DEC_TOP  = 16'hFFFE;
  localparam logic [3:0]  DEC_TOPW = 4'b0000;
`else
  localparam logic [15:0] INC_TOP  = 16'h0000;
  localparam logic [15:0] DEC_ZERO = 16'hFFFF;
  localparam logic [15:0] DEC_TOP  = 16'hFFFF;
  localparam logic [3:0]  DEC_TOPW = 4'b0100;
`endif

  typedef struct {
    logic        rstIn;
    logic [3:0]  en;
    logic [2:0]  fs;
    logic [15:0] ld;
    logic        ls;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [15:0] expA;
    logic [15:0] expB;
    logic [3:0]  expW;
  } vec_t;

  localparam int NVEC = 21;
  vec_t  vecs [NVEC];
  string vecName [NVEC];

  int numChecks = 0;
  int numFails  = 0;

  function automatic vec_t mkVec(logic r, logic [3:0] en, logic [2:0] fs, logic [15:0] ld,
                                 logic ls, logic [1:0] sa, logic [1:0] sb,
                                 logic [15:0] ea, logic [15:0] eb, logic [3:0] ew);
    vec_t v;
    v.rstIn = r;  v.en = en;  v.fs = fs;  v.ld = ld;  v.ls = ls;
    v.sa = sa;    v.sb = sb;  v.expA = ea; v.expB = eb; v.expW = ew;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rstIn;
    bus.enable   = v.en;
    bus.funsel   = v.fs;
    bus.load     = v.ld;
    bus.lane_sel = v.ls;
    bus.sel_a    = v.sa;
    bus.sel_b    = v.sb;
  endtask

  task automatic step2(input string name, input logic [1:0] en, input logic [2:0] fs,
                       input logic [23:0] ld, input logic [1:0] ls, input logic [23:0] expVal);
    bus2.enable   = en;
    bus2.funsel   = fs;
    bus2.load     = ld;
    bus2.lane_sel = ls;
    bus2.sel_a    = 1'b0;
    bus2.sel_b    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, "_a"}, {8'h00, bus2.out_a}, {8'h00, expVal});
    checkOutput({name, "_wrap"}, {30'd0, bus2.wrap}, 32'd0);
  endtask

  initial begin
    // Rows are applied in order; each expectation is the state right after that row's edge.
    vecs[0]  = mkVec(1, 4'b0000, 3'b000, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 4'b0000); vecName[0]  = "reset";
    vecs[1]  = mkVec(0, 4'b0100, 3'b001, 16'hBEEF, 0, 2, 2, 16'hBEEF, 16'hBEEF, 4'b0000); vecName[1]  = "load2_beef";
    vecs[2]  = mkVec(1, 4'b0000, 3'b000, 16'h0000, 0, 2, 0, 16'h0000, 16'h0000, 4'b0000); vecName[2]  = "reset_clears";
    vecs[3]  = mkVec(0, 4'b0001, 3'b001, 16'h1234, 0, 0, 2, 16'h1234, 16'h0000, 4'b0000); vecName[3]  = "full_load";
    vecs[4]  = mkVec(0, 4'b0001, 3'b100, 16'h00AB, 1, 0, 0, 16'hAB34, 16'hAB34, 4'b0000); vecName[4]  = "lane_load1";
    vecs[5]  = mkVec(0, 4'b0001, 3'b100, 16'hFF77, 0, 0, 0, 16'hAB77, 16'hAB77, 4'b0000); vecName[5]  = "lane_load0";
    vecs[6]  = mkVec(0, 4'b0001, 3'b101, 16'hFFFF, 1, 0, 0, 16'h0077, 16'h0077, 4'b0000); vecName[6]  = "lane_clr1";
    vecs[7]  = mkVec(0, 4'b0010, 3'b001, 16'hFFFF, 0, 1, 0, 16'hFFFF, 16'h0077, 4'b0000); vecName[7]  = "load1_ffff";
    vecs[8]  = mkVec(0, 4'b0010, 3'b011, 16'h0000, 0, 1, 0, INC_TOP,  16'h0077, 4'b0010); vecName[8]  = "inc_wrap";
    vecs[9]  = mkVec(0, 4'b0000, 3'b011, 16'h0000, 0, 1, 0, INC_TOP,  16'h0077, 4'b0000); vecName[9]  = "wrap_drops";
    vecs[10] = mkVec(0, 4'b0001, 3'b001, 16'h0005, 0, 0, 3, 16'h0005, 16'h0000, 4'b0000); vecName[10] = "load0_5";
    vecs[11] = mkVec(0, 4'b1001, 3'b010, 16'h0000, 0, 0, 3, 16'h0004, DEC_ZERO, 4'b1000); vecName[11] = "multi_dec";
    vecs[12] = mkVec(0, 4'b0001, 3'b011, 16'h0000, 0, 0, 1, 16'h0005, INC_TOP,  4'b0000); vecName[12] = "inc_plain";
    vecs[13] = mkVec(0, 4'b1111, 3'b110, 16'h1111, 0, 0, 3, 16'h0005, DEC_ZERO, 4'b0000); vecName[13] = "reserved110";
    vecs[14] = mkVec(0, 4'b1111, 3'b111, 16'h2222, 1, 1, 2, INC_TOP,  16'h0000, 4'b0000); vecName[14] = "reserved111";
    vecs[15] = mkVec(1, 4'b1111, 3'b011, 16'h0000, 0, 0, 3, 16'h0000, 16'h0000, 4'b0000); vecName[15] = "rst_priority";
    vecs[16] = mkVec(0, 4'b1000, 3'b001, 16'h5A5A, 0, 3, 3, 16'h5A5A, 16'h5A5A, 4'b0000); vecName[16] = "load3_5a5a";
    vecs[17] = mkVec(0, 4'b0100, 3'b001, 16'hFFFF, 0, 2, 3, 16'hFFFF, 16'h5A5A, 4'b0000); vecName[17] = "load2_ffff";
    vecs[18] = mkVec(0, 4'b0100, 3'b011, 16'h0000, 0, 2, 3, INC_TOP,  16'h5A5A, 4'b0100); vecName[18] = "inc2_wrap";
    vecs[19] = mkVec(0, 4'b0100, 3'b010, 16'h0000, 0, 2, 3, DEC_TOP,  16'h5A5A, DEC_TOPW); vecName[19] = "dec2_back";
    vecs[20] = mkVec(0, 4'b0000, 3'b010, 16'h0000, 0, 2, 3, DEC_TOP,  16'h5A5A, 4'b0000); vecName[20] = "idle";

    rst           = 1'b0;
    bus2.enable   = '0;
    bus2.funsel   = '0;
    bus2.load     = '0;
    bus2.lane_sel = '0;
    bus2.sel_a    = '0;
    bus2.sel_b    = '0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput({vecName[i], "_out_a"}, {16'h0000, bus.out_a}, {16'h0000, vecs[i].expA});
      checkOutput({vecName[i], "_out_b"}, {16'h0000, bus.out_b}, {16'h0000, vecs[i].expB});
      checkOutput({vecName[i], "_wrap"},  {28'd0, bus.wrap},     {28'd0, vecs[i].expW});
    end

    // Write reg3 on the coming edge; both ports must still show the old value until it passes.
    rst        = 1'b0;
    bus.enable = 4'b1000;
    bus.funsel = 3'b001;
    bus.load   = 16'h0001;
    bus.sel_a  = 2'd3;
    bus.sel_b  = 2'd3;
    #2;
    checkOutput("no_bypass_a", {16'h0000, bus.out_a}, 32'h0000_5A5A);
    checkOutput("no_bypass_b", {16'h0000, bus.out_b}, 32'h0000_5A5A);
    @(posedge clk);
    #1;
    bus.enable = 4'b0000;
    checkOutput("after_write_a", {16'h0000, bus.out_a}, 32'h0000_0001);
    checkOutput("after_write_b", {16'h0000, bus.out_b}, 32'h0000_0001);

    // Three-lane instance: lane_sel=3 is out of range and must leave the register alone.
    step2("w24_load",        2'b01, 3'b001, 24'hABCDEF, 2'd0, 24'hABCDEF);
    step2("w24_lane_ld_oor", 2'b01, 3'b100, 24'h000011, 2'd3, 24'hABCDEF);
    step2("w24_lane_cl_oor", 2'b01, 3'b101, 24'h000000, 2'd3, 24'hABCDEF);
    step2("w24_lane_ld_top", 2'b01, 3'b100, 24'h000011, 2'd2, 24'h11CDEF);
    step2("w24_lane_cl_lo",  2'b01, 3'b101, 24'h000000, 2'd0, 24'h11CD00);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
